// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C target endpoint.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StAddr    = ST_ADDR,
        StAddrAck = ST_ADDR_ACK,
        StWrByte  = ST_WR_BYTE,
        StWrAck   = ST_WR_ACK,
        StRdByte  = ST_RD_BYTE,
        StRdAck   = ST_RD_ACK,
        StIgnore  = ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_line_mon.sv
// SCL/SDA line monitor: input synchroniser, optional 3-sample glitch filter
// (enabled by defining I2C_GLITCH_FILTER_EN) and single-cycle bus event pulses.
module i2c_line_mon #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_v;
    logic                   sda_v;
    logic                   scl_h_q;
    logic                   sda_h_q;

    // Bring the asynchronous bus lines into the CLK domain.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_win_q;
    logic [1:0] sda_win_q;
    logic       scl_filt_q;
    logic       sda_filt_q;
    logic       scl_filt_d;
    logic       sda_filt_d;

    // Filtered level follows the line only once three consecutive samples agree.
    always_comb begin
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        if (scl_win_q == {2{scl_s}}) scl_filt_d = scl_s;
        if (sda_win_q == {2{sda_s}}) sda_filt_d = sda_s;
    end

    // Sample window and filtered-level state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_win_q  <= '0;
            sda_win_q  <= '0;
            scl_filt_q <= 1'b0;
            sda_filt_q <= 1'b0;
        end else begin
            scl_win_q  <= {scl_win_q[0], scl_s};
            sda_win_q  <= {sda_win_q[0], sda_s};
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_v = scl_filt_d;
    assign sda_v = sda_filt_d;
`else
    assign scl_v = scl_s;
    assign sda_v = sda_s;
`endif

    // One-cycle history used for edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_h_q <= 1'b0;
            sda_h_q <= 1'b0;
        end else begin
            scl_h_q <= scl_v;
            sda_h_q <= sda_v;
        end
    end

    assign sda_o      = sda_v;
    assign scl_rise_o = scl_v & ~scl_h_q;
    assign scl_fall_o = ~scl_v & scl_h_q;
    // SDA may only move while SCL is high for a START/STOP condition.
    assign start_o    = scl_v & scl_h_q & sda_h_q & ~sda_v;
    assign stop_o     = scl_v & scl_h_q & ~sda_h_q & sda_v;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address, DATA_W-bit words sent as bytes MSB first.
// Glitch filtering on the bus inputs is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h2A,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              scl_i,
    input  logic              sda_in_i,
    output logic              sda_out_o,
    output logic              sda_oe_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_stb_o,
    output logic              addr_hit_o,
    output logic              busy_o
);

    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start;
    logic              stop;

    state_e            state_q;
    logic [3:0]        bit_cnt_q;
    logic [BCW-1:0]    byte_cnt_q;
    logic [6:0]        addr_sh_q;
    logic              rw_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] tx_q;
    logic              sda_out_q;
    logic              sda_oe_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_stb_q;
    logic              addr_hit_q;
    logic              busy_q;

    logic [7:0]        addr_byte;
    logic              last_byte;

    i2c_line_mon #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_mon (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .scl_i     (scl_i),
        .sda_i     (sda_in_i),
        .sda_o     (sda),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    // Address byte including the bit being sampled now; last byte of the current word.
    always_comb begin
        addr_byte = {addr_sh_q, sda};
        last_byte = (byte_cnt_q == BCW'(NBYTES - 1));
    end

    // Protocol FSM. SDA outputs only move on scl_fall, so they settle while SCL is low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            addr_sh_q  <= '0;
            rw_q       <= 1'b0;
            rx_q       <= '0;
            tx_q       <= '0;
            sda_out_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_stb_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            addr_hit_q <= 1'b0;
            wr_stb_q   <= 1'b0;
            if (stop) begin
                state_q    <= StIdle;
                sda_oe_q   <= 1'b0;
                sda_out_q  <= 1'b0;
                busy_q     <= 1'b0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else if (start) begin
                // Covers both first and repeated START; any partial word is dropped.
                state_q    <= StAddr;
                sda_oe_q   <= 1'b0;
                sda_out_q  <= 1'b0;
                busy_q     <= 1'b1;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise) begin
                            addr_sh_q <= addr_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (addr_byte[7:1] == TARGET_ADDR) begin
                                    addr_hit_q <= 1'b1;
                                    tx_q       <= rd_data_i;
                                    byte_cnt_q <= '0;
                                    rw_q       <= addr_byte[0];
                                    state_q    <= StAddrAck;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        // bit_cnt_q marks whether the ACK bit is already on the bus.
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd0) begin
                                sda_oe_q  <= 1'b1;
                                sda_out_q <= ACK;
                                bit_cnt_q <= 4'd1;
                            end else if (rw_q == RW_READ) begin
                                sda_out_q <= tx_q[DATA_W-1];
                                tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                                bit_cnt_q <= 4'd1;
                                state_q   <= StRdByte;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StWrByte;
                            end
                        end
                    end
                    StWrByte: begin
                        if (scl_rise) begin
                            rx_q <= {rx_q[DATA_W-2:0], sda};
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                state_q   <= StWrAck;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd0) begin
                                sda_oe_q  <= 1'b1;
                                sda_out_q <= ACK;
                                bit_cnt_q <= 4'd1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StWrByte;
                                if (last_byte) begin
                                    wr_data_q  <= rx_q;
                                    wr_stb_q   <= 1'b1;
                                    byte_cnt_q <= '0;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + BCW'(1);
                                end
                            end
                        end
                    end
                    StRdByte: begin
                        // bit_cnt_q counts bits already driven; the 8th fall hands SDA back.
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                sda_out_q <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StRdAck;
                            end else begin
                                sda_out_q <= tx_q[DATA_W-1];
                                tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda == NACK) begin
                                state_q <= StIgnore;
                            end else begin
                                bit_cnt_q <= 4'd1;
                                if (last_byte) begin
                                    tx_q       <= rd_data_i;
                                    byte_cnt_q <= '0;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + BCW'(1);
                                end
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            sda_oe_q  <= 1'b1;
                            sda_out_q <= tx_q[DATA_W-1];
                            tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                            bit_cnt_q <= 4'd1;
                            state_q   <= StRdByte;
                        end
                    end
                    StIgnore: ;
                endcase
            end
        end
    end

    assign sda_out_o  = sda_out_q;
    assign sda_oe_o   = sda_oe_q;
    assign wr_data_o  = wr_data_q;
    assign wr_stb_o   = wr_stb_q;
    assign addr_hit_o = addr_hit_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level model
// of what the target should answer.
module tb_i2c_target;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        m_scl;
    logic        m_sda;
    logic        sda_bus;
    logic        sda_out;
    logic        sda_oe;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        addr_hit;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          hit_cnt  = 0;
    int          stb_cnt  = 0;
    int          oe_cnt   = 0;
    int          viol     = 0;
    logic        oe_prev  = 1'b0;

    logic [7:0]  wbytes [8];
    logic [15:0] rwords [4];
    logic [15:0] exp_wr_data = 16'h0000;

    always #5 clk = ~clk;

    // Open-drain style bus: either side can pull SDA low.
    assign sda_bus = m_sda & (sda_oe ? sda_out : 1'b1);

    i2c_target u_dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .scl_i     (m_scl),
        .sda_in_i  (sda_bus),
        .sda_out_o (sda_out),
        .sda_oe_o  (sda_oe),
        .rd_data_i (rd_data),
        .wr_data_o (wr_data),
        .wr_stb_o  (wr_stb),
        .addr_hit_o(addr_hit),
        .busy_o    (busy)
    );

    always @(posedge clk) begin
        if (addr_hit) hit_cnt <= hit_cnt + 1;
        if (wr_stb) stb_cnt <= stb_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (sda_oe !== oe_prev && m_scl) viol <= viol + 1;
        oe_prev <= sda_oe;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic bit_wr(input logic b, output logic oe);
        m_sda = b; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        oe = sda_oe; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bit_rd(output logic b, output logic oe);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = sda_bus; oe = sda_oe; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic byte_wr(input logic [7:0] d, output logic ack);
        logic oe;
        for (int i = 7; i >= 0; i--) bit_wr(d[i], oe);
        bit_rd(ack, oe);
    endtask

    task automatic byte_rd(output logic [7:0] d, input logic mack, output logic oe_slot);
        logic oe;
        for (int i = 7; i >= 0; i--) bit_rd(d[i], oe);
        bit_wr(mack, oe_slot);
    endtask

    // Write transaction of n bytes from wbytes[] to 7-bit address a7.
    task automatic wr_txn(input logic [6:0] a7, input int n);
        logic ack;
        logic match;
        int   hit0;
        int   stb0;
        match = (a7 == 7'h2A);
        hit0  = hit_cnt;
        stb0  = stb_cnt;
        bus_start();
        check_eq("wr_busy", 32'(busy), 32'd1);
        byte_wr({a7, 1'b0}, ack);
        check_eq("wr_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            byte_wr(wbytes[i], ack);
            check_eq("wr_data_ack", 32'(ack), match ? 32'd0 : 32'd1);
        end
        if (match && n >= 2) exp_wr_data = {wbytes[2*(n/2)-2], wbytes[2*(n/2)-1]};
        bus_stop();
        wait_clk(8);
        check_eq("wr_busy_after_stop", 32'(busy), 32'd0);
        check_eq("wr_addr_hit_cnt", 32'(hit_cnt - hit0), match ? 32'd1 : 32'd0);
        check_eq("wr_stb_cnt", 32'(stb_cnt - stb0), match ? 32'(n / 2) : 32'd0);
        check_eq("wr_data", 32'(wr_data), 32'(exp_wr_data));
    endtask

    // Read transaction of n>=1 bytes; word k is offered via rd_data before it is latched.
    task automatic rd_txn(input logic [6:0] a7, input int n);
        logic       ack;
        logic       match;
        logic       oe_slot;
        logic [7:0] d;
        logic [7:0] exp;
        logic [15:0] w;
        int         hit0;
        int         oe0;
        match   = (a7 == 7'h2A);
        hit0    = hit_cnt;
        oe0     = oe_cnt;
        rd_data = rwords[0];
        bus_start();
        check_eq("rd_busy", 32'(busy), 32'd1);
        byte_wr({a7, 1'b1}, ack);
        check_eq("rd_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 1) rd_data = rwords[i/2 + 1];
            byte_rd(d, (i == n - 1), oe_slot);
            w   = rwords[i/2];
            exp = match ? ((i % 2 == 0) ? w[15:8] : w[7:0]) : 8'hFF;
            check_eq("rd_byte", 32'(d), 32'(exp));
            check_eq("rd_ack_slot_oe", 32'(oe_slot), 32'd0);
        end
        bus_stop();
        wait_clk(8);
        check_eq("rd_busy_after_stop", 32'(busy), 32'd0);
        check_eq("rd_addr_hit_cnt", 32'(hit_cnt - hit0), match ? 32'd1 : 32'd0);
        if (!match) check_eq("rd_nomatch_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    endtask

    initial begin
        logic ack;
        logic b;
        logic oe;
        int   hit0;
        int   stb0;
        int   oe0;
        int   seen;

        reset_i = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        rd_data = 16'h0000;
        wait_clk(4);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_sda_out", 32'(sda_out), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_wr_stb", 32'(wr_stb), 32'd0);
        check_eq("rst_addr_hit", 32'(addr_hit), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_i = 1'b0;
        wait_clk(8);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Directed write of 0xBEEF.
        wbytes[0] = 8'hBE;
        wbytes[1] = 8'hEF;
        wr_txn(7'h2A, 2);

        // Directed read of 0xA55A with ACK then NACK.
        rwords[0] = 16'hA55A;
        rwords[1] = 16'h1234;
        rd_txn(7'h2A, 2);

        // Address mismatch: 0x2B.
        wbytes[0] = 8'h11;
        wbytes[1] = 8'h22;
        oe0 = oe_cnt;
        wr_txn(7'h2B, 2);
        check_eq("nomatch_oe_cycles", 32'(oe_cnt - oe0), 32'd0);

        // Abort after a single byte: word discarded.
        wbytes[0] = 8'h12;
        wr_txn(7'h2A, 1);

        // Repeated START in the middle of a byte, then a fresh word 0x0001.
        hit0 = hit_cnt;
        stb0 = stb_cnt;
        bus_start();
        byte_wr(8'h54, ack);
        check_eq("rs_addr_ack", 32'(ack), 32'd0);
        byte_wr(8'h12, ack);
        check_eq("rs_byte_ack", 32'(ack), 32'd0);
        bit_wr(1'b1, oe);
        bit_wr(1'b0, oe);
        bit_wr(1'b1, oe);
        bus_start();
        byte_wr(8'h54, ack);
        check_eq("rs_addr2_ack", 32'(ack), 32'd0);
        byte_wr(8'h00, ack);
        byte_wr(8'h01, ack);
        check_eq("rs_last_ack", 32'(ack), 32'd0);
        bus_stop();
        wait_clk(8);
        exp_wr_data = 16'h0001;
        check_eq("rs_hit_cnt", 32'(hit_cnt - hit0), 32'd2);
        check_eq("rs_stb_cnt", 32'(stb_cnt - stb0), 32'd1);
        check_eq("rs_wr_data", 32'(wr_data), 32'h0001);

        // RESET while the target drives read data.
        rd_data = 16'h0F0F;
        bus_start();
        byte_wr(8'h55, ack);
        check_eq("rr_addr_ack", 32'(ack), 32'd0);
        bit_rd(b, oe);
        bit_rd(b, oe);
        check_eq("rr_drive_oe", 32'(sda_oe), 32'd1);
        reset_i = 1'b1;
        wait_clk(1);
        check_eq("rr_oe_after_reset", 32'(sda_oe), 32'd0);
        check_eq("rr_busy_after_reset", 32'(busy), 32'd0);
        check_eq("rr_wr_data_after_reset", 32'(wr_data), 32'd0);
        exp_wr_data = 16'h0000;
        reset_i = 1'b0;
        wait_clk(4);
        bus_stop();
        wait_clk(8);
        check_eq("rr_busy_idle", 32'(busy), 32'd0);
        wbytes[0] = 8'hC3;
        wbytes[1] = 8'h3C;
        wr_txn(7'h2A, 2);

`ifdef I2C_GLITCH_FILTER_EN
        // SDA low glitches with SCL high: 2 CLK must be ignored, 3 CLK is a START.
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(10);
        seen = 0;
        m_sda = 1'b0;
        wait_clk(2);
        m_sda = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_clk(1);
            if (busy) seen = 1;
        end
        check_eq("glitch2_start", 32'(seen), 32'd0);
        seen = 0;
        m_sda = 1'b0;
        wait_clk(3);
        m_sda = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_clk(1);
            if (busy) seen = 1;
        end
        check_eq("glitch3_start", 32'(seen), 32'd1);
        wait_clk(8);
        check_eq("glitch3_busy_end", 32'(busy), 32'd0);
`endif

        // Randomised transactions.
        for (int t = 0; t < 20; t++) begin
            logic [6:0] a7;
            int         n;
            a7 = ($urandom_range(0, 1) == 1) ? 7'h2A : 7'($urandom_range(0, 127));
            for (int i = 0; i < 8; i++) wbytes[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) rwords[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 5);
                rd_txn(a7, n);
            end else begin
                n = $urandom_range(0, 5);
                wr_txn(a7, n);
            end
        end

        check_eq("oe_change_while_scl_high", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
